// File: rtl/pb_step_conditioner_pkg.sv
// Shared types, timing defaults and counter sizing for the pushbutton conditioner.
package pb_cond_pkg;

   typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} pb_state_e;

   localparam int unsigned DEF_NUM_BTN     = 2;
   localparam int unsigned DEF_DEBOUNCE    = 4;
   localparam int unsigned DEF_REPEAT_DLY  = 50;
   localparam int unsigned DEF_REPEAT_RATE = 10;

   // One counter width serves both the debounce count and the repeat count.
   function automatic int unsigned cnt_width(input int unsigned debounce,
                                             input int unsigned repeat_dly);
      int unsigned m;
      m = (debounce > repeat_dly) ? debounce : repeat_dly;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pb_step_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold-to-repeat counter.
module pb_channel
   import pb_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
   parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
   parameter int unsigned REPEAT_RATE = DEF_REPEAT_RATE
) (
   input  logic hz100,
   input  logic reset,
   input  logic pb_raw,
   input  logic repeat_en,
   output logic level,
   output logic press,
   output logic rel,
   output logic busy
);

   localparam int unsigned W = cnt_width(DEBOUNCE, REPEAT_DLY);

   localparam logic [W-1:0] DB_LAST    = W'(DEBOUNCE - 1);
   localparam logic [W-1:0] RPT_FIRE   = W'(REPEAT_DLY - 1);
   localparam logic [W-1:0] RPT_RELOAD = W'(REPEAT_DLY - REPEAT_RATE);
   localparam logic [W-1:0] RPT_MAX    = {W{1'b1}};
   localparam logic [W-1:0] ONE        = W'(1);

   logic            sync1_q, s_q;
   pb_state_e       state_q, state_d;
   logic [W-1:0]    cnt_q, cnt_d;
   logic [W-1:0]    rpt_q, rpt_d;
   logic            level_q, press_q, rel_q, busy_q;
   logic            press_d, rel_d;

   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         sync1_q <= pb_raw;
         s_q     <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = rpt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_q) begin
               if (DEBOUNCE == 1) begin
                  state_d = HELD;
                  press_d = 1'b1;
                  cnt_d   = '0;
                  rpt_d   = '0;
               end else begin
                  state_d = ARM;
                  cnt_d   = ONE;
               end
            end
         end
         ARM: begin
            if (!s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = HELD;
               press_d = 1'b1;
               cnt_d   = '0;
               rpt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         HELD: begin
            if (!s_q) begin
               // rpt is frozen while the release is being qualified
               if (DEBOUNCE == 1) begin
                  state_d = IDLE;
                  rel_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = DISARM;
                  cnt_d   = ONE;
               end
            end else if (repeat_en && (rpt_q == RPT_FIRE)) begin
               press_d = 1'b1;
               rpt_d   = RPT_RELOAD;
            end else if (rpt_q != RPT_MAX) begin
               rpt_d = rpt_q + ONE;
            end
         end
         DISARM: begin
            if (s_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rpt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rpt_q   <= rpt_d;
         level_q <= (state_d == HELD) || (state_d == DISARM);
         press_q <= press_d;
         rel_q   <= rel_d;
         busy_q  <= (state_d == ARM) || (state_d == DISARM);
      end
   end

   assign level = level_q;
   assign press = press_q;
   assign rel   = rel_q;
   assign busy  = busy_q;

   a_no_press_and_rel: assert property (@(posedge hz100) disable iff (!reset)
                                        !(press_q && rel_q));

endmodule

// File: rtl/pb_step_conditioner.sv
// Pushbutton conditioner top: NUM_BTN independent debounce/strobe channels in the hz100 domain.
// The release strobe port is named rel because release is a reserved word.
module pb_step_conditioner
   import pb_cond_pkg::*;
#(
   parameter int unsigned NUM_BTN     = DEF_NUM_BTN,
   parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
   parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
   parameter int unsigned REPEAT_RATE = DEF_REPEAT_RATE
) (
   input  logic               hz100,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] pb_raw,
   input  logic [NUM_BTN-1:0] repeat_en,
   output logic [NUM_BTN-1:0] level,
   output logic [NUM_BTN-1:0] press,
   output logic [NUM_BTN-1:0] rel,
   output logic [NUM_BTN-1:0] busy
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      pb_channel #(
         .DEBOUNCE    (DEBOUNCE),
         .REPEAT_DLY  (REPEAT_DLY),
         .REPEAT_RATE (REPEAT_RATE)
      ) u_chan (
         .hz100     (hz100),
         .reset     (reset),
         .pb_raw    (pb_raw[i]),
         .repeat_en (repeat_en[i]),
         .level     (level[i]),
         .press     (press[i]),
         .rel       (rel[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_pb_step_conditioner.sv
// Directed bench for pb_step_conditioner with default timing (DEBOUNCE=4, 50/10 repeat).
module tb_pb_step_conditioner;

   logic       hz100 = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] pb_raw = 2'b00;
   logic [1:0] repeat_en = 2'b00;
   logic [1:0] level, press, rel, busy;

   int vectors = 0;
   int errors  = 0;

   always #5 hz100 = ~hz100;

   pb_step_conditioner #(
      .NUM_BTN     (2),
      .DEBOUNCE    (4),
      .REPEAT_DLY  (50),
      .REPEAT_RATE (10)
   ) dut (
      .hz100     (hz100),
      .reset     (reset),
      .pb_raw    (pb_raw),
      .repeat_en (repeat_en),
      .level     (level),
      .press     (press),
      .rel       (rel),
      .busy      (busy)
   );

   // {level, press, rel, busy} of one channel
   function automatic logic [3:0] chan(input int c);
      return {level[c], press[c], rel[c], busy[c]};
   endfunction

   task automatic tick();
      @(posedge hz100);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      pb_raw = 2'b11;
      repeat (3) tick();
      vectors++;
      if ({level, press, rel, busy} !== 8'h00) begin
         errors++;
         $display("FAIL reset_hold got %b exp %b", {level, press, rel, busy}, 8'h00);
      end
      pb_raw = 2'b00;
      tick();
      reset = 1'b1;
      repeat (4) tick();
      vectors++;
      if ({level, press, rel, busy} !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle got %b exp %b", {level, press, rel, busy}, 8'h00);
      end
   endtask

   task automatic test_clean_press();
      logic [3:0] exp0;
      pb_raw[0] = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         exp0 = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
         vectors++;
         if ({chan(1), chan(0)} !== {4'b0000, exp0}) begin
            errors++;
            $display("FAIL clean_press k=%0d got %b exp %b", k, {chan(1), chan(0)},
                     {4'b0000, exp0});
         end
      end
   endtask

   task automatic test_glitch_release();
      logic [3:0] exp0;
      pb_raw[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         exp0 = {1'b1, 1'b0, 1'b0, (k == 2 || k == 3)};
         vectors++;
         if (chan(0) !== exp0) begin
            errors++;
            $display("FAIL glitch k=%0d got %b exp %b", k, chan(0), exp0);
         end
         if (k == 1) pb_raw[0] = 1'b1;
      end
      pb_raw[0] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         exp0 = {(k < 5), 1'b0, (k == 5), (k >= 2 && k <= 4)};
         vectors++;
         if (chan(0) !== exp0) begin
            errors++;
            $display("FAIL release k=%0d got %b exp %b", k, chan(0), exp0);
         end
      end
   endtask

   task automatic test_bounce();
      int pat[6] = '{1, 0, 1, 1, 0, 1};
      int busy_exp[16] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      int presses = 0;
      for (int j = 1; j <= 16; j++) begin
         pb_raw[0] = (j <= 6) ? pat[j-1][0] : 1'b1;
         tick();
         if (press[0]) presses++;
         vectors++;
         if ({busy[0], press[0], level[0]} !== {busy_exp[j-1][0], (j == 11), (j >= 11)}) begin
            errors++;
            $display("FAIL bounce j=%0d got busy/press/level %b exp %b", j,
                     {busy[0], press[0], level[0]}, {busy_exp[j-1][0], (j == 11), (j >= 11)});
         end
      end
      vectors++;
      if (presses != 1) begin
         errors++;
         $display("FAIL bounce_count got %0d exp 1", presses);
      end
      pb_raw[0] = 1'b0;
      repeat (10) tick();
      vectors++;
      if (level[0] !== 1'b0) begin
         errors++;
         $display("FAIL bounce_idle got level %b exp 0", level[0]);
      end
   endtask

   task automatic test_repeat();
      logic [3:0] exp1;
      logic       rp;
      int presses = 0;
      repeat_en[1] = 1'b1;
      pb_raw[1] = 1'b1;
      for (int k = 0; k < 215; k++) begin
         tick();
         if (press[1]) presses++;
         rp = (k == 5) || (k >= 55 && k <= 195 && ((k - 55) % 10) == 0);
         exp1 = {(k >= 5 && k < 205), rp, (k == 205),
                 ((k >= 2 && k <= 4) || (k >= 202 && k <= 204))};
         vectors++;
         if ({chan(1), chan(0)} !== {exp1, 4'b0000}) begin
            errors++;
            $display("FAIL repeat k=%0d got %b exp %b", k, {chan(1), chan(0)}, {exp1, 4'b0000});
         end
         if (k == 199) pb_raw[1] = 1'b0;
      end
      vectors++;
      if (presses != 16) begin
         errors++;
         $display("FAIL repeat_count got %0d exp 16", presses);
      end
      repeat_en[1] = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [3:0] e;
      pb_raw = 2'b11;
      for (int k = 0; k < 10; k++) begin
         tick();
         e = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
         vectors++;
         if ({chan(1), chan(0)} !== {e, e}) begin
            errors++;
            $display("FAIL simul_press k=%0d got %b exp %b", k, {chan(1), chan(0)}, {e, e});
         end
      end
      pb_raw = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick();
         e = {(k < 5), 1'b0, (k == 5), (k >= 2 && k <= 4)};
         vectors++;
         if ({chan(1), chan(0)} !== {e, e}) begin
            errors++;
            $display("FAIL simul_release k=%0d got %b exp %b", k, {chan(1), chan(0)}, {e, e});
         end
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] exp0;
      pb_raw[0] = 1'b1;
      repeat (4) tick();
      vectors++;
      if (chan(0) !== 4'b0001) begin
         errors++;
         $display("FAIL mid_arm_pre got %b exp %b", chan(0), 4'b0001);
      end
      // Two passes: first abort lands in ARM, second in HELD.
      for (int pass = 0; pass < 2; pass++) begin
         #1 reset = 1'b0;
         #1;
         vectors++;
         if ({level, press, rel, busy} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset pass=%0d got %b exp %b", pass,
                     {level, press, rel, busy}, 8'h00);
         end
         reset = 1'b1;
         for (int j = 1; j <= 10; j++) begin
            tick();
            exp0 = {(j >= 6), (j == 6), 1'b0, (j >= 3 && j <= 5)};
            vectors++;
            if (chan(0) !== exp0) begin
               errors++;
               $display("FAIL reacquire pass=%0d j=%0d got %b exp %b", pass, j, chan(0), exp0);
            end
         end
      end
      pb_raw[0] = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch_release();
      test_bounce();
      test_repeat();
      test_simultaneous();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pb_step_conditioner.md
Name: pb_step_conditioner

Overview:
- Upstream conditioning stage for the pushbutton-stepped state machines in the lab designs.
- Turns raw, bouncy, asynchronous pb inputs into clean levels, single-cycle press/release strobes, and optional hold-to-repeat strobes, all in the hz100 domain.
- Downstream FSMs step on `press` as a clock enable, not by using pb[0] as a clock.

Parameters:
- NUM_BTN, 2: number of independent button channels.
- DEBOUNCE, 4: consecutive stable synced samples required to accept a change (40 ms at 100 Hz); minimum 1.
- REPEAT_DLY, 50: cycles from accepted press to first repeat strobe; minimum 2.
- REPEAT_RATE, 10: cycles between subsequent repeat strobes; minimum 2.

Ports:
- hz100, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- pb_raw, input, NUM_BTN: raw button inputs, asynchronous.
- repeat_en, input, NUM_BTN: per-channel hold-to-repeat enable.
- level, output, NUM_BTN: debounced button level.
- press, output, NUM_BTN: one-cycle strobe on accepted press and on each repeat.
- release, output, NUM_BTN: one-cycle strobe on accepted release.
- busy, output, NUM_BTN: a candidate change is being qualified (debug, drives LEDs).

Behaviour:
- Reset (reset low, asynchronous):
  - Synchronizer flops, counters and all outputs clear to 0.
  - Every channel state goes to IDLE.
  - Reset asserted mid-debounce or mid-repeat aborts with no strobe.
  - After release of reset, a button already held is accepted as a normal press after full qualification.
- Sync: 2-flop synchronizer per channel gives s = pb_raw delayed 2 edges. Only s is used after this point.
- Per-channel FSM states: IDLE, ARM, HELD, DISARM.
  - IDLE (level=0): s=1 goes to ARM with cnt=1.
  - ARM (busy=1):
    - s=1 and cnt==DEBOUNCE-1: go to HELD. Registered level=1, press=1 for one cycle, rpt=0.
    - s=1 otherwise: cnt++.
    - s=0: back to IDLE, cnt=0, no strobe (bounce rejected).
    - DEBOUNCE=1: IDLE goes directly to HELD.
  - HELD (level=1):
    - rpt increments each cycle, saturating.
    - s=0 goes to DISARM, cnt=1, rpt frozen.
    - With repeat_en=1: press pulses when rpt==REPEAT_DLY-1, then every REPEAT_RATE cycles after that. rpt reloads to REPEAT_DLY-REPEAT_RATE after each repeat strobe.
    - repeat_en=0 suppresses repeat strobes and rpt keeps counting. Raising repeat_en late makes repeating start at the next qualifying count.
  - DISARM (busy=1, level stays 1, no repeat strobes):
    - s=0 and cnt==DEBOUNCE-1: go to IDLE, level=0, release=1 for one cycle.
    - s=0 otherwise: cnt++.
    - s=1: back to HELD, cnt=0, rpt resumes from its frozen value, no strobe.
- Latency: raw edge set up before edge E gives level change, and the press or release strobe, registered at edge E+1+DEBOUNCE.
- Strobe rules:
  - press and release are never high in the same cycle on the same channel.
  - Strobes never last more than one cycle.
  - Minimum spacing between press strobes is REPEAT_RATE.
- Channels are fully independent; simultaneous events on different channels each produce their own strobes in the same cycle.
- Counter widths: $clog2 of max(DEBOUNCE, REPEAT_DLY)+1. rpt saturates, no wrap.
- All outputs are registered; no combinational path from pb_raw.

Decomposition:
- Package pb_cond_pkg holds:
  - State typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM}.
  - Width helper function.
  - Default timing constants.
- Sub-module pb_channel: one synchronizer, FSM and counters per channel.
- Top generates NUM_BTN instances of pb_channel.

Test Plan:
- Clean press: pb_raw[0] 0→1 held 100 cycles, DEBOUNCE=4.
  - level[0] and press[0] rise at edge 5 after the input change.
  - press[0] is high exactly 1 cycle.
  - No other strobes with repeat_en=0.
- Bounce rejection: pb_raw[0] pattern 1,0,1,1,0,1 then stable 1.
  - Exactly one press[0], 4 cycles after the last 0→1 as seen at s.
  - busy toggles during the pattern.
- Release and glitch:
  - While held, a 2-cycle 0 glitch gives no release and level stays 1.
  - Stable 0 gives release[0]=1 once, with level[0]=0 on the same edge.
- Repeat: repeat_en[1]=1, hold pb_raw[1] 200 cycles, defaults.
  - press[1] at acceptance, then at +50, +60, +70…
  - 16 strobes total before release.
- Simultaneous channels: both buttons rise on the same edge.
  - press=2'b11 on the same cycle.
  - Later both release with release=2'b11.
- Async reset mid-ARM and mid-HELD: reset low for 1 ns between edges.
  - All outputs read 0 immediately.
  - Button still held gives a new press after 2+DEBOUNCE edges.
